// File: rtl/perceptron_y_packer.sv
// perceptron_y_packer
//
// Packs the single-bit decisions coming out of a perceptron into PACK-bit
// words for a downstream consumer. Bit k of a word is the k-th decision
// accepted into that word. A word is offered downstream either when it fills
// up or when flush_i asks for a partially filled word to be sent early.
//
// Ports
//   clk      : single clock, all state updates on the rising edge
//   reset    : synchronous, active-high reset
//   val_i    : upstream decision valid (from perceptron val_o)
//   rdy_o    : ready to accept a decision (to perceptron rdy_i)
//   Y_i      : decision bit (from perceptron Y_o)
//   flush_i  : single-cycle request to emit a partially filled word
//   val_o    : packed word valid
//   rdy_i    : downstream ready
//   word_o   : packed decisions, unused upper bits are 0
//   count_o  : number of valid bits in word_o
//   ones_o   : number of 1 bits in word_o
//   words_o  : running count of words delivered downstream (wraps at 16 bits)

module perceptron_y_packer #(
  parameter int PACK = 8,
  localparam int CW = $clog2(PACK + 1)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            val_i,
  output logic            rdy_o,
  input  logic            Y_i,
  input  logic            flush_i,
  output logic            val_o,
  input  logic            rdy_i,
  output logic [PACK-1:0] word_o,
  output logic [CW-1:0]   count_o,
  output logic [CW-1:0]   ones_o,
  output logic [15:0]     words_o
);

  typedef enum logic {
    COLLECT = 1'b0,
    FULL    = 1'b1
  } state_t;

  state_t          state_q;
  logic [PACK-1:0] word_q;
  logic [CW-1:0]   count_q;
  logic [CW-1:0]   count_inc;
  logic [15:0]     words_q;
  logic [CW-1:0]   ones_cnt;

  assign count_inc = count_q + CW'(1);

  // Handshake flags come straight from the state register, so they are
  // glitch-free and never depend combinationally on the other side.
  assign rdy_o   = (state_q == COLLECT);
  assign val_o   = (state_q == FULL);
  assign word_o  = word_q;
  assign count_o = count_q;
  assign words_o = words_q;
  assign ones_o  = ones_cnt;

  // Population count of the word register. Because bits at or above the
  // count are always zero, this can never exceed count_o.
  always_comb begin
    ones_cnt = '0;
    for (int i = 0; i < PACK; i++) begin
      ones_cnt = ones_cnt + CW'(word_q[i]);
    end
  end

  // Collect/deliver state machine. In COLLECT the incoming bit is OR-ed
  // into position [count]; the upper bits are known to be zero, so OR-ing
  // is the same as writing that bit. A transfer that coincides with a flush
  // is taken first and then the word is closed. In FULL everything upstream
  // is ignored and the word is held until the downstream handshake, which
  // clears the word and returns to COLLECT without a same-cycle bypass.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= COLLECT;
      word_q  <= '0;
      count_q <= '0;
      words_q <= '0;
    end else begin
      case (state_q)
        COLLECT: begin
          if (val_i) begin
            word_q  <= word_q | (PACK'(Y_i) << count_q);
            count_q <= count_inc;
            if ((count_inc == CW'(PACK)) || flush_i) begin
              state_q <= FULL;
            end
          end else if (flush_i && (count_q != '0)) begin
            state_q <= FULL;
          end
        end
        FULL: begin
          if (rdy_i) begin
            state_q <= COLLECT;
            word_q  <= '0;
            count_q <= '0;
            words_q <= words_q + 16'd1;
          end
        end
        default: begin
          state_q <= COLLECT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_perceptron_y_packer.sv
// tb_perceptron_y_packer
//
// Drives perceptron_y_packer with directed sequences followed by random
// traffic. A behavioural model keeps the bits of the current word in a
// queue; whenever the model closes a word the expected word/count/ones is
// pushed onto a scoreboard. A separate monitor pops the scoreboard each time
// the DUT starts presenting a new word and also tracks the handshake flags,
// partial fill and delivered-word counter against the model.

module tb_perceptron_y_packer;

  localparam int PACK = 8;
  localparam int CW   = $clog2(PACK + 1);

  typedef struct {
    logic [PACK-1:0] word;
    logic [CW-1:0]   count;
    logic [CW-1:0]   ones;
  } exp_t;

  logic            clk;
  logic            reset;
  logic            val_i;
  logic            rdy_o;
  logic            Y_i;
  logic            flush_i;
  logic            val_o;
  logic            rdy_i;
  logic [PACK-1:0] word_o;
  logic [CW-1:0]   count_o;
  logic [CW-1:0]   ones_o;
  logic [15:0]     words_o;

  int total = 0;
  int bad   = 0;

  // Reference model state
  bit          m_bits[$];
  bit          m_full;
  logic [15:0] m_words;
  exp_t        sb[$];
  bit          mon_en;

  perceptron_y_packer #(.PACK(PACK)) dut (
    .clk     (clk),
    .reset   (reset),
    .val_i   (val_i),
    .rdy_o   (rdy_o),
    .Y_i     (Y_i),
    .flush_i (flush_i),
    .val_o   (val_o),
    .rdy_i   (rdy_i),
    .word_o  (word_o),
    .count_o (count_o),
    .ones_o  (ones_o),
    .words_o (words_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Build the expected packed word from the model's bit queue
  function automatic exp_t closeWord();
    exp_t e;
    e.word  = '0;
    e.count = CW'(m_bits.size());
    e.ones  = '0;
    foreach (m_bits[k]) begin
      e.word[k] = m_bits[k];
      if (m_bits[k]) e.ones = e.ones + CW'(1);
    end
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, want %0h at %0t", name, act, req, $time);
    end
  endtask

  // Drive one cycle of inputs, advance the model to the state it should
  // hold after the next rising edge, then wait until the falling edge.
  task automatic applyStimulus(input bit v, input bit y, input bit f, input bit r, input bit rst);
    val_i   = v;
    Y_i     = y;
    flush_i = f;
    rdy_i   = r;
    reset   = rst;
    if (rst) begin
      m_bits.delete();
      m_full  = 1'b0;
      m_words = 16'd0;
    end else if (!m_full) begin
      if (v) m_bits.push_back(y);
      if ((m_bits.size() == PACK) || (f && m_bits.size() > 0)) begin
        m_full = 1'b1;
        sb.push_back(closeWord());
      end
    end else if (r) begin
      m_full = 1'b0;
      m_bits.delete();
      m_words = m_words + 16'd1;
    end
    @(negedge clk);
  endtask

  // Monitor: sample shortly after each rising edge
  logic            prev_val = 1'b0;
  logic [PACK-1:0] held_word;
  logic [CW-1:0]   held_count;
  always @(posedge clk) begin
    #1;
    if (mon_en) begin
      checkOutput("mon_val", val_o, m_full);
      checkOutput("mon_rdy", rdy_o, !m_full);
      checkOutput("mon_words", words_o, m_words);
      if (ones_o > count_o) checkOutput("mon_ones_le_count", ones_o, count_o);
      if (val_o && !prev_val) begin
        if (sb.size() == 0) begin
          checkOutput("sb_underflow", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          checkOutput("sb_word", word_o, e.word);
          checkOutput("sb_count", count_o, e.count);
          checkOutput("sb_ones", ones_o, e.ones);
        end
        held_word  = word_o;
        held_count = count_o;
      end else if (val_o) begin
        checkOutput("hold_word", word_o, held_word);
        checkOutput("hold_count", count_o, held_count);
      end else begin
        exp_t p;
        p = closeWord();
        checkOutput("part_count", count_o, p.count);
        checkOutput("part_word", word_o, p.word);
      end
    end
    prev_val = val_o;
  end

  initial begin
    bit [7:0] pat;
    logic [PACK-1:0] w;
    logic [15:0] wc;
    m_full  = 1'b0;
    m_words = 16'd0;
    mon_en  = 1'b0;
    val_i = 0; Y_i = 0; flush_i = 0; rdy_i = 0; reset = 1;
    @(negedge clk);
    applyStimulus(0, 0, 0, 0, 1);
    mon_en = 1'b1;

    // Reset values
    checkOutput("rst_rdy", rdy_o, 1);
    checkOutput("rst_val", val_o, 0);
    checkOutput("rst_word", word_o, 0);
    checkOutput("rst_count", count_o, 0);
    checkOutput("rst_ones", ones_o, 0);
    checkOutput("rst_words", words_o, 0);

    // Full word 1,0,1,1,0,0,0,1
    pat = 8'b1000_1101;
    for (int i = 0; i < 8; i++) applyStimulus(1, pat[i], 0, 1, 0);
    checkOutput("full_val", val_o, 1);
    checkOutput("full_word", word_o, 8'h8D);
    checkOutput("full_count", count_o, 8);
    checkOutput("full_ones", ones_o, 4);
    applyStimulus(1, 1, 0, 1, 0);
    checkOutput("full_words", words_o, 1);
    checkOutput("full_rdy_after", rdy_o, 1);
    checkOutput("full_nobypass_count", count_o, 0);

    // Partial word by flush: 1,1,0
    applyStimulus(1, 1, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0);
    checkOutput("flush_val", val_o, 1);
    checkOutput("flush_word", word_o, 8'h03);
    checkOutput("flush_count", count_o, 3);
    checkOutput("flush_ones", ones_o, 2);
    applyStimulus(0, 0, 0, 1, 0);

    // Transfer together with flush
    applyStimulus(1, 1, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 0);
    applyStimulus(1, 1, 1, 0, 0);
    checkOutput("tflush_word", word_o, 8'h07);
    checkOutput("tflush_count", count_o, 3);
    applyStimulus(0, 0, 0, 1, 0);

    // Backpressure: full word held while rdy_i low
    for (int i = 0; i < 8; i++) applyStimulus(1, 1'($urandom_range(0, 1)), 0, 0, 0);
    w  = word_o;
    wc = words_o;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 1, i[0], 0, 0);
      checkOutput("bp_rdy", rdy_o, 0);
      checkOutput("bp_val", val_o, 1);
      checkOutput("bp_word", word_o, w);
      checkOutput("bp_count", count_o, 8);
    end
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("bp_words_once", words_o, wc + 16'd1);
    applyStimulus(0, 0, 0, 1, 0);
    checkOutput("bp_words_still", words_o, wc + 16'd1);

    // Flush with empty word is ignored
    applyStimulus(0, 0, 1, 1, 0);
    checkOutput("eflush_val", val_o, 0);
    checkOutput("eflush_rdy", rdy_o, 1);

    // Reset mid-word discards it
    applyStimulus(0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) applyStimulus(1, 1, 0, 0, 0);
    applyStimulus(1, 1, 0, 0, 1);
    checkOutput("mrst_count", count_o, 0);
    checkOutput("mrst_word", word_o, 0);
    checkOutput("mrst_words", words_o, 0);
    checkOutput("mrst_val", val_o, 0);
    pat = 8'b0101_0011;
    for (int i = 0; i < 8; i++) applyStimulus(1, pat[i], 0, 0, 0);
    checkOutput("mrst_next_word", word_o, 8'h53);
    applyStimulus(0, 0, 0, 1, 0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 9) < 7,
                    1'($urandom_range(0, 1)),
                    $urandom_range(0, 9) == 0,
                    $urandom_range(0, 1) == 1,
                    $urandom_range(0, 199) == 0);
    end
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 1, 0);
    checkOutput("sb_drained", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
